// File: rtl/mp_add_pkg.sv
// Shared constants for the multi-precision add sequencer: default geometry and FSM encoding.
package mp_add_pkg;

    localparam int MP_WORD_W = 16;
    localparam int MP_WORDS  = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mp_add_sequencer.sv
// Feeds a WORDS*WORD_W operand pair through an external WORD_W adder, LSW first, carry chained.
// Latency: accept on edge k -> out_valid after edge k+WORDS; next accept no sooner than WORDS+2 cycles later.
// Backpressure: in_ready only in IDLE; result held registered and stable until out_ready.
module mp_add_sequencer
    import mp_add_pkg::*;
#(
    parameter int WORD_W = MP_WORD_W,
    parameter int WORDS  = MP_WORDS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORDS*WORD_W-1:0]   in_a,
    input  logic [WORDS*WORD_W-1:0]   in_b,
    input  logic                      in_cin,
    output logic [WORD_W-1:0]         add_a,
    output logic [WORD_W-1:0]         add_b,
    output logic                      add_cin,
    input  logic [WORD_W-1:0]         add_s,
    input  logic                      add_cout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORDS*WORD_W-1:0]   out_sum,
    output logic                      out_cout
);

    localparam int               IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                        state;
    logic [IDX_W-1:0]              idx;
    logic                          carry;
    logic [WORDS-1:0][WORD_W-1:0]  a_reg;
    logic [WORDS-1:0][WORD_W-1:0]  b_reg;
    logic [WORDS-1:0][WORD_W-1:0]  sum_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The adder is combinational, so this word's sum and carry are ready now.
                    sum_reg[idx] <= add_s;
                    carry        <= add_cout;
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Adder inputs are held at zero outside RUN to keep the datapath quiet.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == ST_RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = carry;
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_sum   = sum_reg;
    assign out_cout  = carry;

endmodule
